key_event_avl_slave: RTL and testbench

- Avalon-MM responder peripheral for the Nios II system; the Nios data master is the initiator and this block answers it.
- Debounces the two push-buttons and captures each press, with an 8-bit switch snapshot, into an 8-deep event FIFO that software drains over the bus.
- Also holds an LED register and a level interrupt. Instantiated inside the top level alongside the SoC, on the same 50 MHz clock.

---
 rtl/key_event_avl_slave.sv | 185 ++++++++++++++++++
 tb/tb_key_event_avl_slave.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_avl_slave.sv
`default_nettype none
// ============================================================================
// Module      : key_event_avl_slave
// Description : Avalon-MM responder. Debounces two push-buttons, queues each
//               press with a switch snapshot in an event FIFO, and holds an
//               LED register and a level interrupt.
//               Optional macro KEY_EVENT_TIMESTAMP_EN adds a 16-bit
//               timestamp in event bits 25:10.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_avl_slave #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic [1:0]  key_n,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int                c_AW         = $clog2(FIFO_DEPTH);
    localparam int                c_CW         = c_AW + 1;
    localparam logic [c_CW-1:0]   c_FULL_COUNT = c_CW'(FIFO_DEPTH);

    logic [1:0]       r_key_s1, r_key_s2;
    logic [7:0]       r_sw_s1, r_sw_s2;
    logic [1:0]       r_sync_vld;
    logic [15:0]      r_cnt [2];
    logic [1:0]       r_stable, r_stable_d, r_armed, r_press_mask;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow, r_irq_en, r_irq;
    logic [7:0]       r_led;
    logic [31:0]      r_readdata;

    logic             w_wr, w_rd, w_flush, w_pop, w_push_req, w_push;
    logic             w_empty, w_full, w_ts_en;
    logic [15:0]      w_ts;
    logic [31:0]      w_event, w_status, w_rdata;
    logic [22:0]      w_unused_wdata;

    assign w_unused_wdata = avs_writedata[31:9];

`ifdef KEY_EVENT_TIMESTAMP_EN
    logic [15:0] r_ts;
    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ts <= 16'd0;
        else       r_ts <= r_ts + 16'd1;
    end
    assign w_ts    = r_ts;
    assign w_ts_en = 1'b1;
`else
    assign w_ts    = 16'd0;
    assign w_ts_en = 1'b0;
`endif

    // Two-flop synchronizers; r_sync_vld marks when the key sync output is real
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1   <= 2'b11;
            r_key_s2   <= 2'b11;
            r_sw_s1    <= 8'd0;
            r_sw_s2    <= 8'd0;
            r_sync_vld <= 2'b00;
        end else begin
            r_key_s1   <= key_n;
            r_key_s2   <= r_key_s1;
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // Per-key debounce and press detection. A key is armed only once it has
    // been seen released after reset, so a key held through reset is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt[0]     <= 16'd0;
            r_cnt[1]     <= 16'd0;
            r_stable     <= 2'b11;
            r_stable_d   <= 2'b11;
            r_armed      <= 2'b00;
            r_press_mask <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_key_s2[k] != r_stable[k]) begin
                    if (r_cnt[k] == DEBOUNCE_CYCLES - 16'd1) begin
                        r_stable[k] <= r_key_s2[k];
                        r_cnt[k]    <= 16'd0;
                    end else begin
                        r_cnt[k]    <= r_cnt[k] + 16'd1;
                    end
                end else begin
                    r_cnt[k] <= 16'd0;
                end
                if (r_sync_vld[1] && r_key_s2[k]) r_armed[k] <= 1'b1;
            end
            r_stable_d   <= r_stable;
            r_press_mask <= r_stable_d & ~r_stable & r_armed;
        end
    end

    assign w_wr       = avs_write;
    assign w_rd       = avs_read & ~avs_write;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_flush    = w_wr && (avs_address == 2'd1) && avs_writedata[8];
    assign w_pop      = w_rd && (avs_address == 2'd0) && !w_empty;
    assign w_push_req = |r_press_mask;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push
    assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_event    = {1'b1, 5'd0, w_ts, r_press_mask, r_sw_s2};
    assign w_status   = {22'd0, w_ts_en, 1'b0, r_overflow, w_full, w_empty,
                         5'(r_count)};

    // Event storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_event;
    end

    // FIFO pointers, count and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
            if (w_push_req && !w_flush && w_full && !w_pop)
                r_overflow <= 1'b1;
            else if (w_wr && (avs_address == 2'd1) && avs_writedata[7])
                r_overflow <= 1'b0;
        end
    end

    // Read data selection
    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            2'd0:    w_rdata = w_empty ? 32'd0 : r_mem[r_rd_ptr];
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = {24'd0, r_led};
            default: w_rdata = {31'd0, r_irq_en};
        endcase
    end

    // Control registers, registered read data and interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led      <= 8'd0;
            r_irq_en   <= 1'b0;
            r_readdata <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && avs_address == 2'd2) r_led    <= avs_writedata[7:0];
            if (w_wr && avs_address == 2'd3) r_irq_en <= avs_writedata[0];
            if (w_rd) r_readdata <= w_rdata;
            r_irq <= r_irq_en & ~w_empty;
        end
    end

    assign avs_readdata = r_readdata;
    assign led          = r_led;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_key_event_avl_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_avl_slave
// Description : Directed self-checking bench for key_event_avl_slave
//               (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_avl_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [1:0]  key_n;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    key_event_avl_slave #(
        .DEBOUNCE_CYCLES (16'd4),
        .FIFO_DEPTH      (8)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .key_n         (key_n),
        .sw            (sw),
        .led           (led),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int k);
        key_n[k] = 1'b0;
        wait_cycles(10);
        key_n[k] = 1'b1;
        wait_cycles(10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        logic        seen;

        reset = 1'b1; avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = 32'd0; key_n = 2'b11; sw = 8'h00;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        bus_read(2'd0, d); check("rst_event", d, 32'h0);
        bus_read(2'd1, d); check("rst_status", d, 32'h20);
        bus_read(2'd2, d); check("rst_led_reg", d, 32'h0);
        bus_read(2'd3, d); check("rst_ctrl", d, 32'h0);

        // Single press of key 0 with sw=0xA5
        sw = 8'hA5;
        press_key(0);
        bus_read(2'd1, d); check("one_status", d, 32'h01);
        bus_read(2'd0, d); check("one_event", d, 32'h800001A5);
        bus_read(2'd1, d); check("one_status_after", d, 32'h20);

        // Short glitch must be rejected
        key_n[0] = 1'b0;
        wait_cycles(2);
        key_n[0] = 1'b1;
        wait_cycles(10);
        bus_read(2'd1, d); check("glitch_status", d, 32'h20);

        // Nine presses into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            sw = 8'(i);
            press_key(0);
        end
        bus_read(2'd1, d); check("ovf_status", d, 32'hC8);
        bus_write(2'd1, 32'h80);
        bus_read(2'd1, d); check("ovf_clear", d, 32'h48);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, d);
            check($sformatf("drain_%0d", i), d, 32'h80000100 | 32'(i));
        end
        bus_read(2'd1, d); check("drain_status", d, 32'h20);

        // Interrupt: irq follows the push by one cycle
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, d); check("ctrl_rd", d, 32'h1);
        check("irq_idle", {31'd0, irq}, 32'd0);
        sw = 8'h5A;
        key_n[1] = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (irq) seen = 1'b1;
        end
        check("irq_rise", {31'd0, seen}, 32'd1);
        check("irq_latency", 32'(lat), 32'd9);
        key_n[1] = 1'b1;
        wait_cycles(10);
        bus_read(2'd1, d); check("irq_status", d, 32'h01);
        bus_read(2'd0, d); check("irq_event", d, 32'h8000025A);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);

        bus_write(2'd2, 32'h3C);
        check("led_pin", {24'd0, led}, 32'h3C);
        bus_read(2'd2, d); check("led_rd", d, 32'h3C);

        // Full FIFO: push in the same cycle as an EVENT pop
        for (int i = 0; i < 8; i++) begin
            sw = 8'(8'h10 + i);
            press_key(0);
        end
        bus_read(2'd1, d); check("full_status", d, 32'h48);
        sw = 8'h77;
        wait_cycles(2);
        key_n[1] = 1'b0;
        wait_cycles(7);
        bus_read(2'd0, d); check("same_cycle_pop", d, 32'h80000110);
        key_n[1] = 1'b1;
        wait_cycles(12);
        bus_read(2'd1, d); check("same_cycle_status", d, 32'h48);
        for (int i = 1; i < 8; i++) begin
            bus_read(2'd0, d);
            check($sformatf("tail_drain_%0d", i), d, 32'h80000100 | 32'(8'h10 + i));
        end
        bus_read(2'd0, d); check("tail_event", d, 32'h80000277);
        bus_read(2'd1, d); check("tail_status", d, 32'h20);

        // Flush
        press_key(1);
        bus_write(2'd1, 32'h100);
        bus_read(2'd1, d); check("flush_status", d, 32'h20);
        bus_read(2'd0, d); check("flush_event", d, 32'h0);

        // Key held across reset is not reported until pressed again
        key_n[0] = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);
        check("mid_rst_led", {24'd0, led}, 32'h0);
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        wait_cycles(20);
        bus_read(2'd1, d); check("held_status", d, 32'h20);
        bus_read(2'd3, d); check("held_ctrl", d, 32'h0);
        key_n[0] = 1'b1;
        wait_cycles(20);
        bus_read(2'd1, d); check("held_release", d, 32'h20);
        sw = 8'hC3;
        press_key(0);
        bus_read(2'd1, d); check("repress_status", d, 32'h01);
        bus_read(2'd0, d); check("repress_event", d, 32'h800001C3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
